// File: rtl/instr_fetch.sv
// Instruction fetch: PC/ROM sequencing, LUT-resolved taken branches,
// halt detection and an issued-instruction counter.
module instr_fetch #(
    parameter int         PC_W      = 10,
    parameter logic [8:0] HALT_CODE = 9'h1FF,
    parameter logic [8:0] NOP_CODE  = 9'h000
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Branch,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    input  logic            lut_we,
    input  logic [4:0]      lut_addr,
    input  logic [PC_W-1:0] lut_wdata,
    output logic [8:0]      mach_code,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc_out,
    output logic            Done,
    output logic [15:0]     instr_count
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        HALT
    } state_t;

    state_t          state, state_nx;
    logic [PC_W-1:0] fpc, fpc_nx;
    logic [PC_W-1:0] dpc, dpc_nx;
    logic            squash, squash_nx;
    logic [15:0]     count_nx;
    logic [PC_W-1:0] target;
    logic            is_halt;
    logic            take;
    logic            launch;

    logic [PC_W-1:0] lut [32];

    // Jump table is configuration state and deliberately survives Reset.
    always_ff @(posedge Clk) begin
        if (lut_we) begin
            lut[lut_addr] <= lut_wdata;
        end
    end

    assign target    = lut[imem_data[4:0]];
    assign imem_addr = fpc;
    assign pc_out    = dpc;
    assign Done      = (state == HALT);

    always_comb begin
        state_nx    = state;
        fpc_nx      = fpc;
        dpc_nx      = dpc;
        squash_nx   = 1'b0;
        instr_valid = 1'b0;
        mach_code   = NOP_CODE;
        is_halt     = 1'b0;
        take        = 1'b0;
        launch      = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    launch   = 1'b1;
                    fpc_nx   = '0;
                    state_nx = FILL;
                end
            end
            FILL: begin
                fpc_nx   = PC_W'(1);
                dpc_nx   = '0;
                state_nx = RUN;
            end
            RUN: begin
                is_halt     = !squash && (imem_data == HALT_CODE);
                instr_valid = !squash && !is_halt;
                if (instr_valid) begin
                    mach_code = imem_data;
                end
                take = instr_valid && Branch;
                if (take) begin
                    fpc_nx    = target;
                    dpc_nx    = target;
                    squash_nx = 1'b1;
                end else begin
                    fpc_nx = fpc + PC_W'(1);
                    dpc_nx = fpc;
                end
                if (is_halt) begin
                    state_nx = HALT;
                end
            end
            HALT: begin
                if (Start) begin
                    launch   = 1'b1;
                    fpc_nx   = '0;
                    state_nx = FILL;
                end
            end
        endcase
    end

    always_comb begin
        count_nx = instr_count;
        if (launch) begin
            count_nx = '0;
        end else if (instr_valid && (instr_count != 16'hFFFF)) begin
            count_nx = instr_count + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            fpc         <= '0;
            dpc         <= '0;
            squash      <= 1'b0;
            instr_count <= '0;
        end else begin
            state       <= state_nx;
            fpc         <= fpc_nx;
            dpc         <= dpc_nx;
            squash      <= squash_nx;
            instr_count <= count_nx;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-level model predicts the
// issued (cycle, pc, code) stream; a monitor checks what the DUT issues.
module tb_instr_fetch;

    localparam int PW = 10;
    localparam logic [8:0] HALTC = 9'h1FF;
    localparam logic [8:0] NOPC = 9'h000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic Reset, Start, Branch, lut_we;
    logic [4:0] lut_addr;
    logic [PW-1:0] lut_wdata, imem_addr, pc_out;
    logic [8:0] imem_data, mach_code;
    logic instr_valid, Done;
    logic [15:0] instr_count;

    logic Start4;
    logic [3:0] imem_addr4, pc_out4;
    logic [8:0] imem_data4, mach_code4;
    logic valid4, done4;
    logic [15:0] count4;

    instr_fetch #(.PC_W(PW)) dut (
        .Clk(clk), .Reset(Reset), .Start(Start), .Branch(Branch),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
        .mach_code(mach_code), .instr_valid(instr_valid),
        .pc_out(pc_out), .Done(Done), .instr_count(instr_count)
    );

    instr_fetch #(.PC_W(4)) dut4 (
        .Clk(clk), .Reset(Reset), .Start(Start4), .Branch(1'b0),
        .imem_addr(imem_addr4), .imem_data(imem_data4),
        .lut_we(1'b0), .lut_addr(5'd0), .lut_wdata(4'd0),
        .mach_code(mach_code4), .instr_valid(valid4),
        .pc_out(pc_out4), .Done(done4), .instr_count(count4)
    );

    logic [8:0] rom [1024];
    logic [8:0] rom4 [16];
    always @(posedge clk) imem_data <= rom[imem_addr];
    always @(posedge clk) imem_data4 <= rom4[imem_addr4];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;
    int s;

    bit br_map [1024];
    bit noise_on = 1'b0;
    int noise_pct = 0;
    logic [PW-1:0] lut_m [32];

    bit wen [512];
    logic [4:0] widx [512];
    logic [PW-1:0] wdat [512];

    typedef struct {
        int c;
        int pc;
        logic [8:0] code;
    } exp_t;
    exp_t q[$];
    exp_t e;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Decoder stand-in: branch decision per PC, random noise when no
    // instruction is valid (must be ignored by the DUT).
    initial begin
        Branch = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (instr_valid) Branch = br_map[pc_out];
            else Branch = noise_on && ($urandom_range(99) < noise_pct);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (instr_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_issue: got pc %0d code %0h expected none",
                             pc_out, mach_code);
                end else begin
                    e = q.pop_front();
                    chk("issue_cycle", cyc, e.c);
                    chk("pc_out", 32'(pc_out), e.pc);
                    chk("mach_code", 32'(mach_code), 32'(e.code));
                end
            end else begin
                chk("nop_code", 32'(mach_code), 32'(NOPC));
            end
        end
    end

    task automatic clear_prog(input logic [8:0] fillv);
        for (int i = 0; i < 1024; i++) begin
            rom[i] = fillv;
            br_map[i] = 1'b0;
        end
        for (int k = 0; k < 512; k++) wen[k] = 1'b0;
    endtask

    task automatic rand_prog(input int halt_pct, input int br_pct,
                             input int wr_pct);
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 9'($urandom_range(510));
            if ($urandom_range(99) < halt_pct) rom[i] = HALTC;
            br_map[i] = ($urandom_range(99) < br_pct);
        end
        for (int k = 0; k < 512; k++) begin
            wen[k] = ($urandom_range(99) < wr_pct);
            widx[k] = 5'($urandom);
            wdat[k] = PW'($urandom);
        end
    endtask

    task automatic lut_write(input logic [4:0] a, input logic [PW-1:0] d);
        @(negedge clk);
        lut_we = 1'b1;
        lut_addr = a;
        lut_wdata = d;
        lut_m[a] = d;
        @(negedge clk);
        lut_we = 1'b0;
    endtask

    // Program-level prediction: walk the program, one issue per cycle,
    // one extra cycle after each taken branch; LUT writes count only
    // if made in an earlier cycle than the branch.
    task automatic run(input int cap);
        logic [PW-1:0] lt [32];
        int pc, t, n, th, applied, last_t, r, ee, wlim;
        logic [8:0] code;
        @(negedge clk);
        s = cyc;
        for (int i = 0; i < 32; i++) lt[i] = lut_m[i];
        pc = 0; t = 2; n = 0; th = -1; applied = 0; last_t = 2;
        while (n < cap) begin
            code = rom[pc];
            if (code == HALTC) begin
                th = t;
                break;
            end
            q.push_back('{c: s + t, pc: pc, code: code});
            n++;
            last_t = t;
            if (br_map[pc]) begin
                while (applied < t) begin
                    if (wen[applied]) lt[widx[applied]] = wdat[applied];
                    applied++;
                end
                pc = int'(lt[code[4:0]]);
                t += 2;
            end else begin
                pc = (pc + 1) % 1024;
                t += 1;
            end
        end
        r = last_t;
        ee = (th >= 0) ? th + 2 : r + 2;
        wlim = (th >= 0) ? ee : r;
        for (int k = 0; k < ee; k++) begin
            if (k > 0) @(negedge clk);
            if (th >= 0 && k == th) chk("done_before", 32'(Done), 0);
            if (th >= 0 && k == th + 1) begin
                chk("done_after", 32'(Done), 1);
                chk("count_halt", 32'(instr_count), n);
            end
            if (th < 0 && k == r + 1) begin
                chk("rst_valid", 32'(instr_valid), 0);
                chk("rst_addr", 32'(imem_addr), 0);
                chk("rst_pc", 32'(pc_out), 0);
                chk("rst_done", 32'(Done), 0);
                chk("rst_count", 32'(instr_count), 0);
            end
            Start = (k == 0);
            Reset = (th < 0 && k == r);
            lut_we = (k < wlim) && wen[k];
            lut_addr = widx[k];
            lut_wdata = wdat[k];
        end
        @(negedge clk);
        Start = 1'b0;
        Reset = 1'b0;
        lut_we = 1'b0;
        chk("queue_drained", q.size(), 0);
        q.delete();
        for (int k = 0; k < wlim; k++)
            if (wen[k]) lut_m[widx[k]] = wdat[k];
        repeat (2) @(negedge clk);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Start4 = 1'b0;
        lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;
        clear_prog(9'h010);
        for (int i = 0; i < 16; i++) rom4[i] = 9'($urandom_range(510));
        repeat (3) @(negedge clk);
        chk("reset_addr", 32'(imem_addr), 0);
        chk("reset_pc", 32'(pc_out), 0);
        chk("reset_code", 32'(mach_code), 32'(NOPC));
        chk("reset_valid", 32'(instr_valid), 0);
        chk("reset_done", 32'(Done), 0);
        chk("reset_count", 32'(instr_count), 0);
        Reset = 1'b0;
        for (int i = 0; i < 32; i++) lut_write(5'(i), PW'($urandom));

        // Three-word program ending in halt.
        clear_prog(9'h010);
        rom[0] = 9'h020; rom[1] = 9'h040; rom[2] = HALTC;
        run(100);

        // Branch via LUT[5], noisy Branch in bubbles, same-cycle LUT write.
        lut_write(5'd5, 10'd20);
        clear_prog(9'h010);
        rom[3] = 9'h005; br_map[3] = 1'b1;
        rom[20] = 9'h0A1; rom[21] = 9'h0A2;
        rom[22] = 9'h005; br_map[22] = 1'b1;
        rom[30] = HALTC;
        wen[5] = 1'b1; widx[5] = 5'd5; wdat[5] = 10'd30;
        noise_on = 1'b1; noise_pct = 100;
        run(100);
        chk("lut5_model", 32'(lut_m[5]), 30);

        // Reset mid-run at PC 7, then LUT[5] must still hold 30.
        clear_prog(9'h011);
        run(8);
        clear_prog(9'h012);
        rom[0] = 9'h005; br_map[0] = 1'b1;
        rom[30] = 9'h0B0; rom[31] = HALTC;
        run(100);

        noise_pct = 50;
        for (int it = 0; it < 8; it++) begin
            rand_prog(2, 15, 20);
            run($urandom_range(20, 150));
        end

        // PC_W = 4: 15 wraps to 0 with no bubble.
        @(negedge clk);
        Start4 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            Start4 = 1'b0;
            if (k >= 2) begin
                chk("wrap_valid", 32'(valid4), 1);
                chk("wrap_pc", 32'(pc_out4), (k - 2) % 16);
                chk("wrap_code", 32'(mach_code4), 32'(rom4[(k - 2) % 16]));
                chk("wrap_count", 32'(count4), k - 2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
